// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - host-side load bus for the seven-segment scan driver
interface seg7_scan_driver_if;
  logic        load;
  logic [31:0] digits_in;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;

  modport master (output load, output digits_in, output dp_in, output digit_en);
  modport slave  (input  load, input  digits_in, input  dp_in, input  digit_en);
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - eight-digit multiplexed seven-segment scan driver (optional LEADING_ZERO_BLANK_EN)
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 12500,
  parameter int BLANK_CYCLES = 100
) (
  input  logic                      clk,
  input  logic                      reset_n,
  seg7_scan_driver_if.slave         host,
  output logic [7:0]                an,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [2:0]                scan_idx,
  output logic                      frame_done
);

  localparam logic [19:0] DIV_LAST   = 20'(REFRESH_DIV - 1);
  localparam logic [19:0] BLANK_LAST = (BLANK_CYCLES == 0) ? 20'd0 : 20'(BLANK_CYCLES - 1);

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  scan_idx_q, scan_idx_d;
  logic        frame_done_q, frame_done_d;

  // pending is written by the host at any time; display only changes at frame wrap
  logic [31:0] pend_digits_q, pend_digits_d;
  logic [7:0]  pend_dp_q, pend_dp_d;
  logic [7:0]  pend_en_q, pend_en_d;
  logic [31:0] disp_digits_q, disp_digits_d;
  logic [7:0]  disp_dp_q, disp_dp_d;
  logic [7:0]  disp_en_q, disp_en_d;

  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic        slot_end;
  logic        show;
  logic [3:0]  nibble;

  // active-low {g,f,e,d,c,b,a} patterns for hex digits
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // prescaler, slot sequencing, blank/drive FSM and pending/display transfer
  always_comb begin
    cnt_d         = cnt_q + 20'd1;
    scan_idx_d    = scan_idx_q;
    state_d       = state_q;
    frame_done_d  = 1'b0;
    pend_digits_d = pend_digits_q;
    pend_dp_d     = pend_dp_q;
    pend_en_d     = pend_en_q;
    disp_digits_d = disp_digits_q;
    disp_dp_d     = disp_dp_q;
    disp_en_d     = disp_en_q;
    slot_end      = (cnt_q == DIV_LAST);

    if (slot_end) begin
      cnt_d      = 20'd0;
      scan_idx_d = scan_idx_q + 3'd1;
      state_d    = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
      if (scan_idx_q == 3'd7) begin
        // display takes the pending value held before this edge, so a load
        // landing on the wrap cycle shows one frame later
        frame_done_d  = 1'b1;
        disp_digits_d = pend_digits_q;
        disp_dp_d     = pend_dp_q;
        disp_en_d     = pend_en_q;
      end
    end else if (state_q == ST_BLANK && (BLANK_CYCLES == 0 || cnt_q == BLANK_LAST)) begin
      state_d = ST_DRIVE;
    end

    if (host.load) begin
      pend_digits_d = host.digits_in;
      pend_dp_d     = host.dp_in;
      pend_en_d     = host.digit_en;
    end
  end

  // pin values derived from the current state; registered below for glitch-free outputs
  always_comb begin
    an_d   = 8'hFF;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    nibble = disp_digits_q[{scan_idx_q, 2'b00} +: 4];
    show   = disp_en_q[scan_idx_q];
`ifdef LEADING_ZERO_BLANK_EN
    if (scan_idx_q != 3'd0 && (disp_digits_q >> {scan_idx_q, 2'b00}) == 32'd0) begin
      show = 1'b0;
    end
`endif
    if (state_q == ST_DRIVE) begin
      seg_d = hex_decode(nibble);
      dp_d  = ~disp_dp_q[scan_idx_q];
      if (show) begin
        an_d = ~(8'h01 << scan_idx_q);
      end
    end
  end

  // all state and output flops; reset darkens the display immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_BLANK;
      cnt_q         <= 20'd0;
      scan_idx_q    <= 3'd0;
      frame_done_q  <= 1'b0;
      pend_digits_q <= 32'd0;
      pend_dp_q     <= 8'd0;
      pend_en_q     <= 8'd0;
      disp_digits_q <= 32'd0;
      disp_dp_q     <= 8'd0;
      disp_en_q     <= 8'd0;
      an_q          <= 8'hFF;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      scan_idx_q    <= scan_idx_d;
      frame_done_q  <= frame_done_d;
      pend_digits_q <= pend_digits_d;
      pend_dp_q     <= pend_dp_d;
      pend_en_q     <= pend_en_d;
      disp_digits_q <= disp_digits_d;
      disp_dp_q     <= disp_dp_d;
      disp_en_q     <= disp_en_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign scan_idx   = scan_idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic       clk;
  logic       reset_n;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [2:0] scan_idx;
  logic       frame_done;

  int total;
  int bad;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .host       (bus.slave),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .scan_idx   (scan_idx),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
    bus.load      = 1'b1;
    bus.digits_in = d;
    bus.dp_in     = p;
    bus.digit_en  = e;
    @(negedge clk);
    bus.load      = 1'b0;
  endtask

  // stop on the first negedge of a fresh entry into slot idx (slot offset 0)
  task automatic wait_slot(input logic [2:0] idx);
    logic [2:0] prev;
    logic       found;
    prev  = scan_idx;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (scan_idx == idx && prev != idx) found = 1'b1;
      prev = scan_idx;
    end
    check("wait_slot_timeout", {31'd0, found}, 32'd1);
  endtask

  initial begin
    int   fd_cnt;
    int   fd_pos;
    int   blank_cnt;
    int   multi_low;
    logic lit;

    total         = 0;
    bad           = 0;
    reset_n       = 1'b0;
    bus.load      = 1'b0;
    bus.digits_in = 32'd0;
    bus.dp_in     = 8'd0;
    bus.digit_en  = 8'd0;

    // reset state
    step(3);
    check("rst_an", {24'd0, an}, 32'hFF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_dp", {31'd0, dp}, 32'd1);
    check("rst_scan_idx", {29'd0, scan_idx}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);

    // load during frame 0: nothing shows until the first wrap
    reset_n = 1'b1;
    do_load(32'h76543210, 8'h00, 8'hFF);
    wait_slot(3'd3);
    step(3);
    check("f0_slot3_dark", {24'd0, an}, 32'hFF);
    wait_slot(3'd3);
    step(1);
    check("s3_blank1", {24'd0, an}, 32'hFF);
    step(1);
    check("s3_blank2", {24'd0, an}, 32'hFF);
    step(1);
    check("s3_an", {24'd0, an}, 32'hF7);
    check("s3_seg", {25'd0, seg}, 32'h30);
    check("s3_dp", {31'd0, dp}, 32'd1);

    // free run two frames from a frame_done pulse
    fd_cnt = 0;
    for (int i = 0; i < 200 && frame_done !== 1'b1; i++) @(negedge clk);
    check("fd_found", {31'd0, frame_done}, 32'd1);
    check("fd_scan_idx", {29'd0, scan_idx}, 32'd0);
    fd_pos    = -1;
    blank_cnt = 0;
    multi_low = 0;
    for (int i = 0; i < 128; i++) begin
      if (frame_done === 1'b1) begin
        fd_cnt++;
        if (i != 0) fd_pos = i;
      end
      if (an === 8'hFF) blank_cnt++;
      if ($countones(~an) > 1) multi_low++;
      @(negedge clk);
    end
    check("fd_count", fd_cnt, 32'd2);
    check("fd_period", fd_pos, 32'd64);
    check("blank_cycles", blank_cnt, 32'd32);
    check("one_anode", multi_low, 32'd0);

    // mid-frame loads do not tear the current frame; latest load wins
    wait_slot(3'd4);
    do_load(32'h11111111, 8'h00, 8'hFF);
    step(2);
    check("tear_s4_an", {24'd0, an}, 32'hEF);
    check("tear_s4_seg", {25'd0, seg}, 32'h19);
    wait_slot(3'd5);
    step(3);
    check("tear_s5_seg", {25'd0, seg}, 32'h12);
    wait_slot(3'd6);
    do_load(32'h22222222, 8'h00, 8'hFF);
    step(2);
    check("tear_s6_seg", {25'd0, seg}, 32'h02);
    wait_slot(3'd7);
    step(3);
    check("tear_s7_seg", {25'd0, seg}, 32'h78);
    wait_slot(3'd0);
    step(3);
    check("new_s0_an", {24'd0, an}, 32'hFE);
    check("new_s0_seg", {25'd0, seg}, 32'h24);
    wait_slot(3'd5);
    step(3);
    check("new_s5_seg", {25'd0, seg}, 32'h24);

    // partial enables and a single decimal point
    do_load(32'h22222222, 8'h01, 8'h05);
    for (int k = 0; k < 8; k++) begin
      wait_slot(3'(k));
      step(3);
      check($sformatf("en_an_%0d", k), {24'd0, an},
            (k == 0) ? 32'hFE : (k == 2) ? 32'hFB : 32'hFF);
      check($sformatf("en_dp_%0d", k), {31'd0, dp}, (k == 0) ? 32'd0 : 32'd1);
    end

    // leading-zero handling
    do_load(32'h00000A00, 8'h00, 8'hFF);
    for (int k = 0; k < 8; k++) begin
      wait_slot(3'(k));
      step(3);
`ifdef LEADING_ZERO_BLANK_EN
      lit = (k <= 2);
`else
      lit = 1'b1;
`endif
      check($sformatf("lz_an_%0d", k), {24'd0, an}, lit ? {24'd0, ~(8'h01 << k)} : 32'hFF);
      if (lit) check($sformatf("lz_seg_%0d", k), {25'd0, seg}, (k == 2) ? 32'h08 : 32'h40);
    end

    // asynchronous reset while slot 5 drives
    wait_slot(3'd5);
    step(4);
    check("pre_rst_an", {24'd0, an}, 32'hDF);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_an", {24'd0, an}, 32'hFF);
    check("async_seg", {25'd0, seg}, 32'h7F);
    check("async_scan_idx", {29'd0, scan_idx}, 32'd0);
    check("async_frame_done", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
    check("rel_blank1", {24'd0, an}, 32'hFF);
    check("rel_scan_idx", {29'd0, scan_idx}, 32'd0);
    step(1);
    check("rel_blank2", {24'd0, an}, 32'hFF);
    do_load(32'h00000000, 8'h00, 8'hFF);
    wait_slot(3'd0);
    step(3);
    check("rel_zero_an", {24'd0, an}, 32'hFE);
    check("rel_zero_seg", {25'd0, seg}, 32'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 12500, clk cycles per digit slot; legal range BLANK_CYCLES+2 to 2^20.
REQ-002 SHALL have parameter BLANK_CYCLES, default 100, anode dead-time cycles at the start of each slot; legal range 0 to 1023.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port load  input  1  capture digits_in/dp_in/digit_en into the pending register this cycle.
REQ-006 SHALL have port digits_in  input  32  eight hex nibbles; nibble k = digits_in[4k+3:4k] drives digit k.
REQ-007 SHALL have port dp_in  input  8  decimal point per digit, 1 = lit.
REQ-008 SHALL have port digit_en  input  8  per-digit enable, 0 = slot stays dark.
REQ-009 SHALL have port an  output  8  anodes, active-low, at most one bit low.
REQ-010 SHALL have port seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port dp  output  1  decimal-point cathode, active-low.
REQ-012 SHALL have port scan_idx  output  3  current digit slot.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse on slot wrap 7->0.

Function
REQ-014 SHALL run prescaler cnt 0..REFRESH_DIV-1; at cnt=REFRESH_DIV-1: cnt<=0, scan_idx<=scan_idx+1 (7 wraps to 0), state<=BLANK.
REQ-015 SHALL implement states BLANK, DRIVE: BLANK holds BLANK_CYCLES cycles then goes DRIVE; with BLANK_CYCLES=0, BLANK is skipped (slot change enters DRIVE directly).
REQ-016 SHALL, in BLANK, force an=8'hFF, seg=7'h7F, dp=1.
REQ-017 SHALL, in DRIVE with digit_en[scan_idx]=1, drive an[scan_idx]=0, others 1, seg=hex decode of nibble, dp=~dp_in[scan_idx]; with enable 0, an=8'hFF.
REQ-018 SHALL decode hex (active-low, {g..a}): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-019 SHALL register an/seg/dp so they reflect state/scan_idx with exactly one clk latency and are glitch-free.
REQ-020 SHALL hold loaded data in a pending register; latest load wins, multiple loads per frame allowed.
REQ-021 SHALL copy pending to display register only on the cycle scan_idx wraps 7->0 (no tearing mid-frame); load coinciding with wrap is captured to pending and displayed from the next frame.
REQ-022 SHALL assert frame_done for exactly one cycle, the same cycle scan_idx becomes 0.

Reset
REQ-023 SHALL on reset_n=0 immediately set an=8'hFF, seg=7'h7F, dp=1, scan_idx=0, frame_done=0, cnt=0, state=BLANK, pending and display registers all 0.
REQ-024 SHALL, on reset mid-slot, abandon the slot; after release begin BLANK at slot 0 showing zeros once digit_en loads.
REQ-025 SHALL keep at most one anode low at every clk edge, including across reset assertion and release.

Configuration
REQ-026 SHALL, with LEADING_ZERO_BLANK_EN defined, blank (an high) every digit k whose nibble and all higher nibbles (k..7) are zero, except digit 0, which always shows.
REQ-027 SHALL, without LEADING_ZERO_BLANK_EN, display every enabled digit, zeros included.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-028 SHALL cover: release reset, load digits_in=32'h76543210, digit_en=FF -> data appears from the first wrap; slot 3 shows an=F7, seg=30 after 2 blank cycles + 1.
REQ-029 SHALL cover: free run 64 cycles -> frame_done pulses every 64 cycles, an=FF for exactly 2 cycles per slot, never two anodes low.
REQ-030 SHALL cover: load 32'h11111111 during slot 4, then 32'h22222222 during slot 6 -> slots 4-7 still show old data, next frame all slots seg=24.
REQ-031 SHALL cover: digit_en=8'h05, dp_in=8'h01 -> only slots 0 and 2 light; dp=0 only in slot 0.
REQ-032 SHALL cover: with LEADING_ZERO_BLANK_EN, digits_in=32'h00000A00 -> digits 7..3 dark, digit 2 seg=08, digits 1,0 seg=40; without macro all eight lit.
REQ-033 SHALL cover: assert reset_n=0 during slot 5 DRIVE -> an=FF same cycle (asynchronous), scan_idx=0, after release BLANK precedes any drive.
